// File: rtl/midi_pkg.sv
// Shared types, note frequency table and threshold rule for the MIDI note quantizer.
package midi_pkg;

  localparam int NOTE_W     = 7;
  localparam int DEF_FREQ_W = 32;
  localparam int TBL_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Rounded equal-temperament note frequencies in Hz (A4 = note 69 = 440 Hz).
  localparam logic [TBL_W-1:0] MIDI_FREQ [0:127] = '{
    16'd8,     16'd9,     16'd9,     16'd10,    16'd10,    16'd11,
    16'd12,    16'd12,    16'd13,    16'd14,    16'd15,    16'd15,
    16'd16,    16'd17,    16'd18,    16'd19,    16'd21,    16'd22,
    16'd23,    16'd24,    16'd26,    16'd28,    16'd29,    16'd31,
    16'd33,    16'd35,    16'd37,    16'd39,    16'd41,    16'd44,
    16'd46,    16'd49,    16'd52,    16'd55,    16'd58,    16'd62,
    16'd65,    16'd69,    16'd73,    16'd78,    16'd82,    16'd87,
    16'd92,    16'd98,    16'd104,   16'd110,   16'd117,   16'd123,
    16'd131,   16'd139,   16'd147,   16'd156,   16'd165,   16'd175,
    16'd185,   16'd196,   16'd208,   16'd220,   16'd233,   16'd247,
    16'd262,   16'd277,   16'd294,   16'd311,   16'd330,   16'd349,
    16'd370,   16'd392,   16'd415,   16'd440,   16'd466,   16'd494,
    16'd523,   16'd554,   16'd587,   16'd622,   16'd659,   16'd698,
    16'd740,   16'd784,   16'd831,   16'd880,   16'd932,   16'd988,
    16'd1047,  16'd1109,  16'd1175,  16'd1245,  16'd1319,  16'd1397,
    16'd1480,  16'd1568,  16'd1661,  16'd1760,  16'd1865,  16'd1976,
    16'd2093,  16'd2217,  16'd2349,  16'd2489,  16'd2637,  16'd2794,
    16'd2960,  16'd3136,  16'd3322,  16'd3520,  16'd3729,  16'd3951,
    16'd4186,  16'd4435,  16'd4699,  16'd4978,  16'd5274,  16'd5588,
    16'd5920,  16'd6272,  16'd6645,  16'd7040,  16'd7459,  16'd7902,
    16'd8372,  16'd8870,  16'd9397,  16'd9956,  16'd10548, 16'd11175,
    16'd11840, 16'd12544
  };

  // Lower edge of note n's capture band: midpoint (rounded up) between neighbours.
  function automatic logic [TBL_W-1:0] note_thr(input logic [NOTE_W-1:0] n);
    logic [TBL_W:0] sum;
    if (n == 7'd0) begin
      sum = 17'd0;
    end else begin
      sum = {1'b0, MIDI_FREQ[n - 7'd1]} + {1'b0, MIDI_FREQ[n]} + 17'd1;
    end
    return sum[TBL_W:1];
  endfunction

endpackage

// File: rtl/midi_note_threshold_rom.sv
// Combinational lookup of a note's capture threshold and nominal frequency.
module midi_note_threshold_rom
  import midi_pkg::*;
(
  input  logic [NOTE_W-1:0] idx_i,
  output logic [TBL_W-1:0]  thr_o,
  output logic [TBL_W-1:0]  freq_o
);

  assign thr_o  = note_thr(idx_i);
  assign freq_o = MIDI_FREQ[idx_i];

endmodule

// File: rtl/midi_note_quantizer.sv
// Frequency-to-nearest-MIDI-note quantizer: 7-step binary search over the threshold
// table, then signed error versus the chosen note and range flags.
module midi_note_quantizer
  import midi_pkg::*;
#(
  parameter int FREQ_W     = DEF_FREQ_W,
  parameter int LOW_LIMIT  = 8,
  parameter int HIGH_LIMIT = 12912
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FREQ_W-1:0] freq_hz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NOTE_W-1:0] note,
  output logic [15:0]       err_hz,
  output logic              too_low,
  output logic              too_high
);

  localparam int CMP_W  = FREQ_W + 1;
  localparam int DIFF_W = FREQ_W + 2;
  localparam logic signed [DIFF_W-1:0] ERR_MAX = DIFF_W'(32'sd32767);
  localparam logic signed [DIFF_W-1:0] ERR_MIN = DIFF_W'(-32'sd32768);

  state_e              state_q, state_d;
  logic [2:0]          bit_q, bit_d;
  logic [NOTE_W-1:0]   n_q, n_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [15:0]         err_q, err_d;
  logic                too_low_q, too_low_d;
  logic                too_high_q, too_high_d;

  logic [NOTE_W-1:0]        cand_s;
  logic [TBL_W-1:0]         thr_cand_s;
  logic [TBL_W-1:0]         freq_cand_s;
  logic [TBL_W-1:0]         thr_n_s;
  logic [TBL_W-1:0]         freq_n_s;
  logic                     ge_s;
  logic signed [DIFF_W-1:0] diff_s;

  assign cand_s = n_q | (7'd1 << bit_q);

  midi_note_threshold_rom u_rom_cand (
    .idx_i  (cand_s),
    .thr_o  (thr_cand_s),
    .freq_o (freq_cand_s)
  );

  midi_note_threshold_rom u_rom_note (
    .idx_i  (n_q),
    .thr_o  (thr_n_s),
    .freq_o (freq_n_s)
  );

  // Compare in one extra bit so the widest frequency never wraps.
  assign ge_s   = {1'b0, freq_q} >= CMP_W'(thr_cand_s);
  assign diff_s = $signed({2'b00, freq_q}) - $signed(DIFF_W'(freq_n_s));

  // Next-state, search step and result capture.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    n_d        = n_q;
    freq_d     = freq_q;
    note_d     = note_q;
    err_d      = err_q;
    too_low_d  = too_low_q;
    too_high_d = too_high_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          freq_d  = freq_hz;
          n_d     = 7'd0;
          bit_d   = 3'd6;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (ge_s) begin
          n_d = cand_s;
        end else begin
          n_d = n_q;
        end
        if (bit_q == 3'd0) begin
          state_d = CALC;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      CALC: begin
        note_d = n_q;
        if (diff_s > ERR_MAX) begin
          err_d = 16'h7fff;
        end else if (diff_s < ERR_MIN) begin
          err_d = 16'h8000;
        end else begin
          err_d = diff_s[15:0];
        end
        too_low_d  = freq_q < FREQ_W'(LOW_LIMIT);
        too_high_d = freq_q > FREQ_W'(HIGH_LIMIT);
        state_d    = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // out_valid asserts one cycle into DONE, giving the 9-edge latency.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_q       <= 3'd0;
      n_q         <= 7'd0;
      freq_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      note_q      <= 7'd0;
      err_q       <= 16'd0;
      too_low_q   <= 1'b0;
      too_high_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      n_q         <= n_d;
      freq_q      <= freq_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      note_q      <= note_d;
      err_q       <= err_d;
      too_low_q   <= too_low_d;
      too_high_q  <= too_high_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign note      = note_q;
  assign err_hz    = err_q;
  assign too_low   = too_low_q;
  assign too_high  = too_high_q;

endmodule

// File: tb/tb_midi_note_quantizer.sv
// Randomized and directed self-checking bench for midi_note_quantizer; the reference
// derives note frequencies from the equal-temperament formula and scans linearly.
module tb_midi_note_quantizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] freq_hz = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  note;
  logic [15:0] err_hz;
  logic        too_low;
  logic        too_high;

  int checks = 0;
  int errors = 0;
  longint ftab [0:127];

  midi_note_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .freq_hz   (freq_hz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .note      (note),
    .err_hz    (err_hz),
    .too_low   (too_low),
    .too_high  (too_high)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input longint f, output int en, output longint ee,
                                output bit el, output bit eh);
    en = 0;
    for (int n = 1; n < 128; n++) begin
      if (f >= (ftab[n-1] + ftab[n] + 1) / 2) en = n;
    end
    ee = f - ftab[en];
    if (ee > 32767) ee = 32767;
    if (ee < -32768) ee = -32768;
    el = (f < 8);
    eh = (f > 12912);
  endfunction

  // One full request; hold>0 keeps out_ready low that many cycles in DONE.
  task automatic xact(input logic [31:0] f, input int hold, input bit junk);
    int k;
    int en;
    longint ee;
    bit el, eh;
    model(longint'(f), en, ee, el, eh);
    out_ready = (hold == 0);
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check_val("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    freq_hz  = f;
    @(posedge clk); #1;
    in_valid = junk;
    freq_hz  = junk ? $urandom : f;
    check_val("busy_in_ready", in_ready, 0);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check_val("latency", k, 9);
    check_val("note", note, en);
    check_val("err", $signed(err_hz), ee);
    check_val("too_low", too_low, el);
    check_val("too_high", too_high, eh);
    for (int c = 0; c < hold; c++) begin
      in_valid = c[0];
      freq_hz  = $urandom;
      @(posedge clk); #1;
      check_val("bp_valid", out_valid, 1);
      check_val("bp_note", note, en);
      check_val("bp_err", $signed(err_hz), ee);
      check_val("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("post_valid", out_valid, 0);
    check_val("post_in_ready", in_ready, 1);
  endtask

  task automatic directed(input logic [31:0] f, input int en, input longint ee,
                          input bit el, input bit eh);
    xact(f, 0, 1'b0);
    check_val("dir_note", note, en);
    check_val("dir_err", $signed(err_hz), ee);
    check_val("dir_low", too_low, el);
    check_val("dir_high", too_high, eh);
  endtask

  initial begin
    int any_valid;
    logic [31:0] f;
    for (int n = 0; n < 128; n++) begin
      ftab[n] = longint'($rtoi(440.0 * (2.0 ** ((n - 69) / 12.0)) + 0.5));
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_note", note, 0);
    check_val("rst_err", err_hz, 0);
    check_val("rst_flags", {too_low, too_high}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rel_in_ready", in_ready, 1);

    directed(32'd440, 69, 0, 1'b0, 1'b0);
    directed(32'd452, 69, 12, 1'b0, 1'b0);
    directed(32'd453, 70, -13, 1'b0, 1'b0);
    directed(32'd0, 0, -8, 1'b1, 1'b0);
    directed(32'd20000, 127, 7456, 1'b0, 1'b1);
    directed(32'hffff_ffff, 127, 32767, 1'b0, 1'b1);
    directed(32'd9, 2, 0, 1'b0, 1'b0);
    directed(32'd8, 0, 0, 1'b0, 1'b0);
    directed(32'd12912, 127, 368, 1'b0, 1'b0);
    directed(32'd12913, 127, 369, 1'b0, 1'b1);

    for (int n = 0; n < 128; n++) xact(ftab[n][31:0], 0, 1'b0);

    xact(32'd1000, 5, 1'b1);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: f = $urandom;
        1: f = $urandom_range(0, 13500);
        2: begin
          int n;
          n = $urandom_range(1, 127);
          f = 32'((ftab[n-1] + ftab[n] + 1) / 2) + 32'($urandom_range(0, 2)) - 32'd1;
        end
        default: f = $urandom_range(0, 600);
      endcase
      xact(f, (i % 7 == 3) ? int'($urandom_range(1, 5)) : 0, 1'($urandom_range(0, 1)));
    end

    // Reset during the search must clear outputs and drop the request.
    xact(32'd20000, 0, 1'b0);
    in_valid = 1'b1;
    freq_hz  = 32'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("amid_note", note, 0);
    check_val("amid_err", err_hz, 0);
    check_val("amid_high", too_high, 0);
    check_val("amid_in_ready", in_ready, 0);
    check_val("amid_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    any_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) any_valid++;
    end
    check_val("amid_no_out", any_valid, 0);
    directed(32'd440, 69, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
